// File: rtl/rf_wb_arbiter_if.sv
// Handshake and lookup bundle between the writeback sources, the hazard unit
// and the register-file write-port arbiter.
interface rf_wb_arbiter_if #(
    parameter int DWIDTH = 32
);
    logic              s0_valid_i;
    logic [4:0]        s0_rd_i;
    logic [DWIDTH-1:0] s0_data_i;
    logic              s1_valid_i;
    logic              s1_ready_o;
    logic [4:0]        s1_rd_i;
    logic [DWIDTH-1:0] s1_data_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic              rs1_pending_o;
    logic              rs2_pending_o;
    logic              stall_o;
    logic              rf_wren_o;
    logic [4:0]        rf_rd_o;
    logic [DWIDTH-1:0] rf_data_o;

    modport slave (
        input  s0_valid_i, s0_rd_i, s0_data_i,
        input  s1_valid_i, s1_rd_i, s1_data_i,
        input  rs1_i, rs2_i,
        output s1_ready_o, rs1_pending_o, rs2_pending_o, stall_o,
        output rf_wren_o, rf_rd_o, rf_data_o
    );

    modport master (
        output s0_valid_i, s0_rd_i, s0_data_i,
        output s1_valid_i, s1_rd_i, s1_data_i,
        output rs1_i, rs2_i,
        input  s1_ready_o, rs1_pending_o, rs2_pending_o, stall_o,
        input  rf_wren_o, rf_rd_o, rf_data_o
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, long-latency
// results queue in a small FIFO with WAW squash, pending lookup and anti-starvation.
module rf_wb_arbiter #(
    parameter int DWIDTH       = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    rf_wb_arbiter_if.slave     bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_BUBBLE} state_t;

    logic [FIFO_DEPTH-1:0]             r_vld;
    logic [FIFO_DEPTH-1:0]             r_sq;
    logic [FIFO_DEPTH-1:0][4:0]        r_rd;
    logic [FIFO_DEPTH-1:0][DWIDTH-1:0] r_data;
    logic [PW-1:0]                     r_head, r_tail;
    logic [CW-1:0]                     r_count;

    logic              r_wren, r_out_s1;
    logic [4:0]        r_out_rd;
    logic [DWIDTH-1:0] r_out_data;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_starve, w_starve_nxt, w_starve_inc;

    logic w_full, w_empty, w_hs, w_enq, w_s0_live, w_pop, w_block;
    logic w_p1, w_p2;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    // Ready depends only on the registered count; held low while in reset.
    assign bus.s1_ready_o = rst & ~w_full;
    assign w_hs      = bus.s1_valid_i & bus.s1_ready_o;
    assign w_enq     = w_hs & (bus.s1_rd_i != 5'd0);
    assign w_s0_live = bus.s0_valid_i & (bus.s0_rd_i != 5'd0);
    assign w_pop     = ~bus.s0_valid_i & ~w_empty;
    assign w_block   = bus.s0_valid_i & ~w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld   <= '0;
            r_sq    <= '0;
            r_rd    <= '0;
            r_data  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Source 0 is younger than any queued write to the same rd.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_s0_live && r_vld[i] && (r_rd[i] == bus.s0_rd_i))
                    r_sq[i] <= 1'b1;
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= ptr_inc(r_head);
            end
            if (w_enq) begin
                r_vld[r_tail]  <= 1'b1;
                r_sq[r_tail]   <= w_s0_live && (bus.s1_rd_i == bus.s0_rd_i);
                r_rd[r_tail]   <= bus.s1_rd_i;
                r_data[r_tail] <= bus.s1_data_i;
                r_tail         <= ptr_inc(r_tail);
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wren     <= 1'b0;
            r_out_s1   <= 1'b0;
            r_out_rd   <= '0;
            r_out_data <= '0;
        end else if (bus.s0_valid_i) begin
            r_wren     <= bus.s0_rd_i != 5'd0;
            r_out_s1   <= 1'b0;
            r_out_rd   <= bus.s0_rd_i;
            r_out_data <= bus.s0_data_i;
        end else if (w_pop) begin
            r_wren     <= ~r_sq[r_head];
            r_out_s1   <= 1'b1;
            r_out_rd   <= r_rd[r_head];
            r_out_data <= r_data[r_head];
        end else begin
            r_wren   <= 1'b0;
            r_out_s1 <= 1'b0;
        end
    end

    assign bus.rf_wren_o = r_wren;
    assign bus.rf_rd_o   = r_out_rd;
    assign bus.rf_data_o = r_out_data;

    always_comb begin
        w_p1 = 1'b0;
        w_p2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_vld[i] && !r_sq[i] && (r_rd[i] == bus.rs1_i)) w_p1 = 1'b1;
            if (r_vld[i] && !r_sq[i] && (r_rd[i] == bus.rs2_i)) w_p2 = 1'b1;
        end
        if (r_wren && r_out_s1 && (r_out_rd == bus.rs1_i)) w_p1 = 1'b1;
        if (r_wren && r_out_s1 && (r_out_rd == bus.rs2_i)) w_p2 = 1'b1;
    end

    assign bus.rs1_pending_o = w_p1 & (bus.rs1_i != 5'd0);
    assign bus.rs2_pending_o = w_p2 & (bus.rs2_i != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    assign w_starve_inc = r_starve + 8'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        case (r_state)
            S_IDLE: begin
                if (w_block) begin
                    w_state_nxt  = S_COUNT;
                    w_starve_nxt = 8'd1;
                end
            end
            S_COUNT: begin
                if (w_pop) begin
                    w_state_nxt  = S_IDLE;
                    w_starve_nxt = '0;
                end else if (w_block) begin
                    w_starve_nxt = w_starve_inc;
                    if (w_starve_inc >= 8'(STARVE_LIMIT)) w_state_nxt = S_BUBBLE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_starve_nxt = '0;
            end
        endcase
    end

    assign bus.stall_o = (r_state == S_BUBBLE);
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a vector table for single-cycle behaviour plus
// hand-written contention, full/starvation and mid-operation reset sequences.
module tb_rf_wb_arbiter;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DWIDTH(DW)) bus();

    rf_wb_arbiter #(.DWIDTH(DW), .FIFO_DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        s0v;
        logic [4:0]  s0rd;
        logic [31:0] s0d;
        logic        s1v;
        logic [4:0]  s1rd;
        logic [31:0] s1d;
        logic [4:0]  rs1, rs2;
        logic        wren;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rdy, p1, p2, stall;
    } vec_t;

    vec_t tbl[15];
    int n_chk  = 0;
    int n_pass = 0;

    function automatic vec_t mk(input logic s0v, input logic [4:0] s0rd, input logic [31:0] s0d,
                                input logic s1v, input logic [4:0] s1rd, input logic [31:0] s1d,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic wren, input logic [4:0] rd, input logic [31:0] data,
                                input logic rdy, input logic p1, input logic p2, input logic stall);
        vec_t v;
        v.s0v = s0v; v.s0rd = s0rd; v.s0d = s0d;
        v.s1v = s1v; v.s1rd = s1rd; v.s1d = s1d;
        v.rs1 = rs1; v.rs2 = rs2;
        v.wren = wren; v.rd = rd; v.data = data;
        v.rdy = rdy; v.p1 = p1; v.p2 = p2; v.stall = stall;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s0v, input logic [4:0] s0rd, input logic [31:0] s0d,
                         input logic s1v, input logic [4:0] s1rd, input logic [31:0] s1d,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        bus.s0_valid_i = s0v; bus.s0_rd_i = s0rd; bus.s0_data_i = s0d;
        bus.s1_valid_i = s1v; bus.s1_rd_i = s1rd; bus.s1_data_i = s1d;
        bus.rs1_i = rs1; bus.rs2_i = rs2;
    endtask

    // rd/data are only meaningful when a write is expected.
    function automatic logic [63:0] obs(input logic mask);
        return {22'd0, bus.rf_wren_o, mask ? bus.rf_rd_o : 5'd0, mask ? bus.rf_data_o : 32'd0,
                bus.s1_ready_o, bus.rs1_pending_o, bus.rs2_pending_o, bus.stall_o};
    endfunction

    function automatic logic [63:0] wr(input logic en, input logic [4:0] rd, input logic [31:0] d);
        return {26'd0, en, rd, d};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            s0v s0rd s0d           s1v s1rd s1d      rs1 rs2 | wren rd data        rdy p1 p2 st
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  5, 0,  1, 5, 32'hDEADBEEF, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 32'h123,      0, 0, 32'h0,  0, 0,  0, 0, 32'h0,        1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 32'h0,        1, 0, 32'h55, 0, 0,  0, 0, 32'h0,        1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0,  0, 0, 32'h0,        1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 32'h0,        1, 9, 32'h99, 9, 0,  0, 0, 32'h0,        1, 1, 0, 0);
        tbl[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  9, 0,  1, 9, 32'h99,       1, 1, 0, 0);
        tbl[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  9, 0,  0, 0, 32'h0,        1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 32'h0,        1, 7, 32'hAA, 7, 9,  0, 0, 32'h0,        1, 1, 0, 0);
        tbl[8]  = mk(1, 7, 32'hBB,       0, 0, 32'h0,  7, 0,  1, 7, 32'hBB,       1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  7, 0,  0, 0, 32'h0,        1, 0, 0, 0);
        tbl[10] = mk(1, 8, 32'h1,        1, 8, 32'h2,  8, 0,  1, 8, 32'h1,        1, 0, 0, 0);
        tbl[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,  8, 0,  0, 0, 32'h0,        1, 0, 0, 0);
        tbl[12] = mk(1, 4, 32'hCAFE,     1, 3, 32'h33, 3, 4,  1, 4, 32'hCAFE,     1, 1, 0, 0);
        tbl[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,  3, 4,  1, 3, 32'h33,       1, 1, 0, 0);
        tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,  3, 4,  0, 0, 32'h0,        1, 0, 0, 0);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        #12;
        chk("reset_outputs", obs(1'b1), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_release", {63'd0, bus.s1_ready_o}, 64'd1);

        foreach (tbl[i]) begin
            drive(tbl[i].s0v, tbl[i].s0rd, tbl[i].s0d, tbl[i].s1v, tbl[i].s1rd, tbl[i].s1d,
                  tbl[i].rs1, tbl[i].rs2);
            step();
            chk($sformatf("vec%0d", i), obs(tbl[i].wren),
                {22'd0, tbl[i].wren, tbl[i].rd, tbl[i].data, tbl[i].rdy, tbl[i].p1, tbl[i].p2, tbl[i].stall});
        end

        // Contention: x6 waits behind three pipeline writes.
        drive(1, 1, 32'hA, 1, 6, 32'h11, 6, 0); step();
        chk("cont_c1", {obs(1'b1)}, {22'd0, 1'b1, 5'd1, 32'hA, 4'b1100});
        drive(1, 2, 32'hB, 0, 0, 0, 6, 0); step();
        chk("cont_c2", {obs(1'b1)}, {22'd0, 1'b1, 5'd2, 32'hB, 4'b1100});
        drive(1, 3, 32'hC, 0, 0, 0, 6, 0); step();
        chk("cont_c3", {obs(1'b1)}, {22'd0, 1'b1, 5'd3, 32'hC, 4'b1100});
        drive(0, 0, 0, 0, 0, 0, 6, 0); step();
        chk("cont_pop", {obs(1'b1)}, {22'd0, 1'b1, 5'd6, 32'h11, 4'b1100});
        step();
        chk("cont_clear", {obs(1'b0)}, {22'd0, 1'b0, 5'd0, 32'h0, 4'b1000});

        // Full FIFO and starvation bubble with the pipeline always busy.
        for (int b = 1; b <= 10; b++) begin
            if (b == 1)      drive(1, 1, 32'(b), 1, 10, 32'hA0, 12, 11);
            else if (b == 2) drive(1, 1, 32'(b), 1, 11, 32'hA1, 12, 11);
            else             drive(1, 1, 32'(b), 1, 12, 32'hA2, 12, 11);
            step();
            chk($sformatf("full_ready_b%0d", b), {63'd0, bus.s1_ready_o}, {63'd0, b == 1});
            chk($sformatf("full_stall_b%0d", b), {63'd0, bus.stall_o}, {63'd0, b == 9});
            chk($sformatf("full_s0_b%0d", b), wr(bus.rf_wren_o, bus.rf_rd_o, bus.rf_data_o),
                wr(1'b1, 5'd1, 32'(b)));
        end
        drive(0, 0, 0, 1, 12, 32'hA2, 12, 11); step();
        chk("starve_head", obs(1'b1), {22'd0, 1'b1, 5'd10, 32'hA0, 4'b1010});
        drive(0, 0, 0, 1, 12, 32'hA2, 12, 11); step();
        chk("starve_second", obs(1'b1), {22'd0, 1'b1, 5'd11, 32'hA1, 4'b1110});
        drive(0, 0, 0, 0, 0, 0, 12, 11); step();
        chk("starve_third", obs(1'b1), {22'd0, 1'b1, 5'd12, 32'hA2, 4'b1100});
        step();
        chk("starve_idle", obs(1'b0), {22'd0, 1'b0, 5'd0, 32'h0, 4'b1000});

        // Reset with two entries queued: nothing may be written afterwards.
        drive(1, 2, 32'h0, 1, 13, 32'hD, 13, 14); step();
        drive(1, 2, 32'h0, 1, 14, 32'hE, 13, 14); step();
        drive(0, 0, 0, 0, 0, 0, 13, 14);
        chk("pre_reset_pending", {62'd0, bus.rs1_pending_o, bus.rs2_pending_o}, 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_outputs", obs(1'b1), 64'd0);
        step();
        step();
        chk("midreset_hold", obs(1'b1), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_ready", {63'd0, bus.s1_ready_o}, 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("no_stale_%0d", k), obs(1'b0), {22'd0, 1'b0, 5'd0, 32'h0, 4'b1000});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
